// File: rtl/bcd_countdown_ctrl_pkg.sv
// Shared types and helpers for the BCD countdown controller and its digit cells.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] nibble);
    return (nibble <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_countdown_ctrl_if.sv
// Host-side control strobes and status of the countdown controller.
// Strobes carry no ready: each is sampled on every clock edge and the controller
// alone decides acceptance; a rejected load is reported by a one-cycle err pulse.
interface bcd_countdown_ctrl_if #(
  parameter int NDIG = 2
);
  import bcd_pkg::*;

  logic                   load;
  logic [BCD_W*NDIG-1:0]  load_val;
  logic                   start;
  logic                   pause;
  logic                   abort;
  logic [BCD_W*NDIG-1:0]  q;
  logic                   busy;
  logic                   done;
  logic                   err;
  state_t                 state;

  modport master (
    output load, load_val, start, pause, abort,
    input  q, busy, done, err, state
  );

  modport slave (
    input  load, load_val, start, pause, abort,
    output q, busy, done, err, state
  );

endinterface

// File: rtl/bcd_countdown_ctrl_digit_dec.sv
// One BCD digit of the down-counter chain: decrements when borrowed from,
// wrapping 0 to 9 and passing the borrow on to the next digit.
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] d_next,
  output logic             borrow_out
);

  always_comb begin
    d_next     = d;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (d == 4'd0) begin
        d_next     = 4'd9;
        borrow_out = 1'b1;
      end else begin
        d_next = d - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_ctrl.sv
// Multi-digit BCD countdown timer: preset load with validation, prescaled
// decrement through a digit borrow chain, pause/resume/abort, one-cycle done.
module bcd_countdown_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIG     = 2,
  parameter int TICK_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_countdown_ctrl_if.slave  bus
);

  localparam int            QW     = BCD_W * NDIG;
  localparam int            PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  state_t          state_q;
  state_t          state_d;
  logic [QW-1:0]   q_q;
  logic [PW-1:0]   presc_q;
  logic            err_q;
  logic [QW-1:0]   q_dec;
  logic [NDIG:0]   borrow;
  logic            tick;
  logic            dec_zero;
  logic            load_ok;
  logic            busy;
  logic            done;

  // A decrement edge: terminal prescale in RUN, not pre-empted by abort or pause.
  assign tick = (state_q == RUN) && !bus.abort && !bus.pause && (presc_q == P_LAST);
  assign borrow[0] = tick;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_digit_dec u_dig (
      .d          (q_q[g*BCD_W +: BCD_W]),
      .borrow_in  (borrow[g]),
      .d_next     (q_dec[g*BCD_W +: BCD_W]),
      .borrow_out (borrow[g+1])
    );
  end

  // A borrow out of the top digit would mean q was already zero; never a finish.
  assign dec_zero = tick && (q_dec == '0) && !borrow[NDIG];

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (!bcd_valid(bus.load_val[i*BCD_W +: BCD_W])) load_ok = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic; priority abort > load > pause > start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!bus.abort && !bus.load && bus.start)
          state_d = (q_q == '0) ? DONE : RUN;
      end
      RUN: begin
        if (bus.abort)      state_d = IDLE;
        else if (bus.pause) state_d = PAUSE;
        else if (dec_zero)  state_d = DONE;
      end
      PAUSE: begin
        if (bus.abort)      state_d = IDLE;
        else if (bus.start) state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN, PAUSE: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // Count, prescaler and load-error datapath.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q     <= '0;
      presc_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (bus.abort) begin
        q_q     <= '0;
        presc_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.load) begin
              if (load_ok) q_q   <= bus.load_val;
              else         err_q <= 1'b1;
            end else if (bus.start) begin
              presc_q <= '0;
            end
          end
          RUN: begin
            if (!bus.pause) begin
              if (presc_q == P_LAST) begin
                presc_q <= '0;
                q_q     <= q_dec;
              end else begin
                presc_q <= presc_q + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.q     = q_q;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.err   = err_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// Directed bench for bcd_countdown_ctrl with three prescale settings (1, 3, 4).
module tb_bcd_countdown_ctrl;
  import bcd_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic bad_nibble;

  bcd_countdown_ctrl_if #(.NDIG(2)) i1 ();
  bcd_countdown_ctrl_if #(.NDIG(2)) i3 ();
  bcd_countdown_ctrl_if #(.NDIG(2)) i4 ();

  bcd_countdown_ctrl #(.NDIG(2), .TICK_DIV(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  bcd_countdown_ctrl #(.NDIG(2), .TICK_DIV(3)) u3 (.clk(clk), .rst(rst), .bus(i3));
  bcd_countdown_ctrl #(.NDIG(2), .TICK_DIV(4)) u4 (.clk(clk), .rst(rst), .bus(i4));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // any non-BCD nibble on any counter is latched for a final check
  initial bad_nibble = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (i1.q[3:0] > 4'd9 || i1.q[7:4] > 4'd9 ||
          i3.q[3:0] > 4'd9 || i3.q[7:4] > 4'd9 ||
          i4.q[3:0] > 4'd9 || i4.q[7:4] > 4'd9)
        bad_nibble = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int v;
    checks   = 0;
    failures = 0;
    rst = 1'b0;
    {i1.load, i1.start, i1.pause, i1.abort} = '0; i1.load_val = '0;
    {i3.load, i3.start, i3.pause, i3.abort} = '0; i3.load_val = '0;
    {i4.load, i4.start, i4.pause, i4.abort} = '0; i4.load_val = '0;
    step(); step();
    rst = 1'b1;
    step();

    // reset mid-RUN with q=37
    i1.load = 1'b1; i1.load_val = 8'h37; step();
    i1.load = 1'b0; i1.start = 1'b1;     step();
    i1.start = 1'b0;
    check("run_entered", i1.state, 32'd1);
    check("run_busy",    i1.busy,  32'd1);
    step();
    check("first_dec",   i1.q,     32'h36);
    rst = 1'b0; step();
    rst = 1'b1;
    check("rst_q",     i1.q,     32'h00);
    check("rst_state", i1.state, 32'd0);
    check("rst_busy",  i1.busy,  32'd0);
    check("rst_done",  i1.done,  32'd0);
    check("rst_err",   i1.err,   32'd0);

    // full count from 10 with TICK_DIV=1
    i1.load = 1'b1; i1.load_val = 8'h10; step();
    i1.load = 1'b0; i1.start = 1'b1;     step();
    i1.start = 1'b0;
    check("full_start_q", i1.q, 32'h10);
    for (int i = 1; i <= 10; i++) begin
      step();
      v = 10 - i;
      check("full_q", i1.q, 32'(((v / 10) << 4) | (v % 10)));
      if (i < 10) check("full_done_low", i1.done, 32'd0);
    end
    check("full_done_state", i1.state, 32'd3);
    check("full_done_high",  i1.done,  32'd1);
    step();
    check("full_idle",     i1.state, 32'd0);
    check("full_done_end", i1.done,  32'd0);

    // invalid load rejected, valid load accepted
    i1.load = 1'b1; i1.load_val = 8'h05; step();
    check("load05_q",   i1.q,   32'h05);
    check("load05_err", i1.err, 32'd0);
    i1.load_val = 8'h1A; step();
    i1.load = 1'b0;
    check("bad_q",   i1.q,   32'h05);
    check("bad_err", i1.err, 32'd1);
    step();
    check("bad_err_end", i1.err, 32'd0);
    i1.load = 1'b1; i1.load_val = 8'h99; step();
    i1.load = 1'b0;
    check("load99_q",   i1.q,   32'h99);
    check("load99_err", i1.err, 32'd0);

    // load during RUN is ignored without err
    i1.start = 1'b1; step();
    i1.start = 1'b0; i1.load = 1'b1; i1.load_val = 8'h1A; step();
    i1.load = 1'b0;
    check("runload_q",   i1.q,   32'h98);
    check("runload_err", i1.err, 32'd0);
    i1.abort = 1'b1; step();
    i1.abort = 1'b0;

    // abort from PAUSE at q=07
    i1.load = 1'b1; i1.load_val = 8'h07; step();
    i1.load = 1'b0; i1.start = 1'b1;     step();
    i1.start = 1'b0; i1.pause = 1'b1;    step();
    i1.pause = 1'b0;
    check("pause_state", i1.state, 32'd2);
    check("pause_q",     i1.q,     32'h07);
    i1.abort = 1'b1; step();
    i1.abort = 1'b0;
    check("abort_q",     i1.q,     32'h00);
    check("abort_state", i1.state, 32'd0);
    check("abort_done",  i1.done,  32'd0);
    step();
    check("abort_done_after", i1.done, 32'd0);

    // start with q=0
    i1.start = 1'b1; step();
    i1.start = 1'b0;
    check("zero_state", i1.state, 32'd3);
    check("zero_done",  i1.done,  32'd1);
    check("zero_q",     i1.q,     32'h00);
    step();
    check("zero_idle",     i1.state, 32'd0);
    check("zero_done_end", i1.done,  32'd0);

    // borrow and prescale, TICK_DIV=3
    i3.load = 1'b1; i3.load_val = 8'h20; step();
    i3.load = 1'b0; i3.start = 1'b1;     step();
    i3.start = 1'b0;
    step(); step();
    check("div3_hold", i3.q, 32'h20);
    step();
    check("div3_borrow", i3.q, 32'h19);
    i3.abort = 1'b1; step();
    i3.abort = 1'b0;

    // pause/resume, TICK_DIV=4, value 3: 12 counting cycles in total
    i4.load = 1'b1; i4.load_val = 8'h03; step();
    i4.load = 1'b0; i4.start = 1'b1;     step();
    i4.start = 1'b0;
    step();
    i4.pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_state", i4.state, 32'd2);
      check("hold_q",     i4.q,     32'h03);
    end
    i4.pause = 1'b0; i4.start = 1'b1; step();
    i4.start = 1'b0;
    check("resume_state", i4.state, 32'd1);
    n = 0;
    while (i4.state !== DONE && n < 20) begin
      step();
      n++;
    end
    check("resume_cycles", 32'(n), 32'd11);
    check("resume_q",      i4.q,   32'h00);
    step();
    check("resume_idle", i4.state, 32'd0);

    check("nonbcd", bad_nibble, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_ctrl.md
# bcd_countdown_ctrl

Controller that sequences a chain of BCD down-counter digits as a multi-digit countdown timer. It loads a preset from a host, decrements the whole BCD value once per prescaled tick with digit-to-digit borrow, and supports pause/resume/abort. It signals completion with a one-cycle `done` pulse. It sits between control logic (buttons/CPU strobes) and the BCD display path that consumes `q`.

## Interface
- `NDIG`, 2: number of BCD digits; `q` width is 4*NDIG.
- `TICK_DIV`, 1: RUN-state cycles per decrement, ≥1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `load`  in  1  load strobe; honoured in IDLE only.
- `load_val`  in  4*NDIG  preset, digit 0 in [3:0].
- `start`  in  1  start from IDLE, resume from PAUSE.
- `pause`  in  1  RUN → PAUSE.
- `abort`  in  1  any state → IDLE, clears `q`.
- `q`  out  4*NDIG  current count, BCD.
- `busy`  out  1  high in RUN or PAUSE.
- `done`  out  1  high exactly while state = DONE.
- `err`  out  1  one-cycle pulse on rejected load.
- `state`  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

## Operation
- Reset (`rst`=0 at an edge): `q`=0, state=IDLE, prescaler=0, `busy`=0, `done`=0, `err`=0. Reset wins over all inputs in every state.
- Input priority per edge: abort > load > pause > start.
- IDLE, load:
  - If every nibble of `load_val` is ≤9: `q`←`load_val`.
  - Otherwise: `q` is unchanged and `err`=1 for the next cycle.
  - A load in any other state is ignored and does not pulse `err`.
- IDLE, start:
  - `q`≠0: go to RUN and clear the prescaler.
  - `q`=0: go directly to DONE. `q` stays 0.
- RUN:
  - The prescaler counts 0..TICK_DIV-1.
  - At an edge with prescaler = TICK_DIV-1: prescaler←0 and `q` decrements by one BCD count.
  - Decrement rule: digit 0 decrements. A digit at 0 wraps to 9 and borrows from the next digit. A digit at 9 never wraps up.
  - If the decrement yields all-zero: next state DONE.
- RUN, pause: go to PAUSE. Prescaler and `q` hold. No decrement occurs on that edge, even if the prescaler is terminal.
- PAUSE: start → RUN with the prescaler value retained. pause is ignored.
- DONE: lasts exactly one cycle, then IDLE. start, pause and load are ignored in DONE; abort is honoured.
- Abort (any state except reset): `q`←0, prescaler←0, state←IDLE, no `done`.
- Simultaneous pause and start in RUN: pause wins. In PAUSE: start wins, because pause has no effect there.
- `q` never holds a non-BCD nibble.

## Timing
- All outputs are registered or decoded from registered state. No combinational input→output path.
- Start sampled at edge k:
  - state=RUN after edge k.
  - First decrement at edge k+TICK_DIV.
  - n-th decrement at edge k+n·TICK_DIV.
- Load value V (decimal), started at edge k:
  - `q` reaches 0 at edge k+V·TICK_DIV; DONE starts on that same edge.
  - IDLE after edge k+V·TICK_DIV+1.
- Start with `q`=0 at edge k: DONE after edge k, IDLE after edge k+1.
- `err` is high for the one cycle following the rejecting edge.
- Pause costs zero cycles of count. Total RUN cycles to completion stay V·TICK_DIV.

## Structure
- Shared package `bcd_pkg`:
  - state enum {IDLE, RUN, PAUSE, DONE} with the encodings listed above.
  - Constant `BCD_W`=4.
  - Function `bcd_valid(nibble)`.
- Sub-module `bcd_digit_dec`: one digit, with inputs `d[3:0]` and `borrow_in`, and outputs `d_next[3:0]` and `borrow_out`. `NDIG` instances are chained by generate, with `borrow_in` of digit 0 = decrement enable.
- The FSM, the prescaler and the load-validation logic live in the top module.

## Test plan
- Reset: drive `rst`=0 mid-RUN with `q`=8'h37 → after the edge, `q`=0, state=0, `busy`=0, `done`=0, `err`=0.
- Full count, NDIG=2, TICK_DIV=1: load 8'h10, start at edge k → `q` goes 10,09,08,…,01,00 on successive edges, reaching 00 after edge k+10. `done` is high for exactly one cycle after edge k+10, then state=IDLE.
- Borrow and prescale, TICK_DIV=3: load 8'h20, start → `q`=8'h19 after 3 RUN cycles. The value never reaches 1F.
- Invalid load: load 8'h1A with `q`=8'h05 → `q` stays 05 and `err` pulses for 1 cycle. A load of 8'h99 then succeeds with `err`=0.
- Pause/resume: TICK_DIV=4, load 8'h03, pause two cycles after start, hold pause 10 cycles, then start → total RUN cycles until `done` = 12. `q` is frozen during PAUSE.
- Abort and start-at-zero:
  - Abort at `q`=8'h07 in PAUSE → `q`=0, IDLE, `done` never asserts.
  - Start with `q`=0 → `done` is high for one cycle, state goes DONE then IDLE.
